// File: rtl/srl_fifo_reader_if.sv
// srl_fifo_reader_if: push/pop handshake and status bundle for the SRL FIFO
interface srl_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [5:0]       count;
  logic             almost_full;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/srl_fifo_reader.sv
// srl_fifo_reader: valid/ready FIFO over a 32-tap shift-register column read at tap count-1
module srl_fifo_reader #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28
) (
  input logic                clk_i,
  input logic                rst_ni,
  srl_fifo_reader_if.slave   bus
);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;
  state_e           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] mem_q [32];
  logic             push, pop;
  logic [4:0]       addr;
  assign bus.in_ready    = state_q != FULL;
  assign bus.out_valid   = state_q != EMPTY;
  assign bus.count       = count_q;
  assign bus.almost_full = af_q;
  // push is gated by reset so the column never shifts while held in reset
  assign push = bus.in_valid & bus.in_ready & rst_ni;
  assign pop  = bus.out_valid & bus.out_ready;
  assign addr = count_q == 6'd0 ? 5'd0 : 5'(count_q - 6'd1);
  assign bus.out_data = mem_q[addr];
  always_comb begin
    count_d = count_q + {5'd0, push} - {5'd0, pop};
    state_d = count_d == 6'd0 ? EMPTY : count_d == 6'(DEPTH) ? FULL : PARTIAL;
    af_d    = count_d >= 6'(AF_LEVEL);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      count_q <= 6'd0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      af_q    <= af_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int i = 31; i > 0; i--) mem_q[i] <= mem_q[i-1];
      mem_q[0] <= bus.in_data;
    end
  end
endmodule
